// File: rtl/aura_mem_arbiter_pkg.sv
// Purpose : shared memory-interface types and requester IDs for the AURA memory arbiter.
// Latency : n/a (types, constants and a helper function only).
// Backpr. : n/a.
//
// Contents: ADDR / MEM_BLOCK / MEM_TAG bus types, the MEM_COMMAND encoding,
// the requester ID enum, and a small wrap-increment helper for round-robin pointers.
package aura_mem_arbiter_pkg;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  localparam int NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  // Requester slot numbering used by the arbiter's request vectors.
  typedef enum logic [1:0] {
    REQ_Q = 2'd0,
    REQ_K = 2'd1,
    REQ_V = 2'd2,
    REQ_O = 2'd3
  } req_id_e;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/aura_mem_arbiter_if.sv
// Purpose : bundles the requester-side and memory-side signals of the AURA memory arbiter.
// Latency : n/a (wires only).
// Backpr. : req_ready is the per-requester accept; memory stalls by returning transaction tag 0.
//
// Modports:
//   master - the environment: loaders/writer plus the memory model
//   slave  - the arbiter: consumes requests and memory replies, drives commands and responses
interface aura_mem_arbiter_if
  import aura_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  // requester side
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][63:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  MEM_BLOCK                 rsp_data;

  // memory side
  MEM_COMMAND               proc2mem_command;
  ADDR                      proc2mem_addr;
  MEM_BLOCK                 proc2mem_data;
  MEM_TAG                   mem2proc_transaction_tag;
  MEM_BLOCK                 mem2proc_data;
  MEM_TAG                   mem2proc_data_tag;

  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

endinterface

// File: rtl/aura_rr_arbiter.sv
// Purpose : round-robin pick of the first eligible requester at or after a pointer.
// Latency : purely combinational.
// Backpr. : none; the caller decides whether the grant is taken and advances ptr.
//
// Ports: elig (eligibility vector), ptr (search start) -> gnt_vld, gnt_oh (one-hot), gnt_idx.
module aura_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld      = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/aura_mem_arbiter.sv
// Purpose : shares the single unified-memory port between the Q/K/V loaders and the O writer.
// Latency : command issue is combinational; load data reaches rsp_valid 1 cycle after its data tag.
// Backpr. : memory tag 0 stalls the selected requester (held, pointer frozen); a requester with
//           MAX_OUTST loads in flight is skipped for loads until one of its responses returns.
//
// Ports: clock, reset (sync, active-high), bus (slave modport: requests, responses, memory
// command/reply), idle (no request pending and no load outstanding), err_orphan_tag (sticky).
module aura_mem_arbiter
  import aura_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_TAGS  = NUM_MEM_TAGS,
  parameter int MAX_OUTST = 8
) (
  input  logic              clock,
  input  logic              reset,
  aura_mem_arbiter_if.slave bus,
  output logic              idle,
  output logic              err_orphan_tag
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] owner;
  } tag_entry_t;

  // registered state
  logic [IW-1:0]      rr_ptr;
  tag_entry_t         tag_tbl     [NUM_TAGS];
  logic [CW-1:0]      outst_cnt   [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_valid_q;
  MEM_BLOCK           rsp_data_q;
  logic               err_q;
  // Counts down the first two cycles after reset; orphan data in that window is
  // traffic from before the reset and is dropped without raising the error.
  logic [1:0]         quiet_cnt;

  // next-state and decode
  tag_entry_t         tag_tbl_nxt   [NUM_TAGS];
  logic [CW-1:0]      outst_cnt_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] inc_v;
  logic [NUM_REQ-1:0] dec_v;
  logic [IW-1:0]      sel;
  logic               gnt_vld;
  logic               accept;
  logic               alloc;
  logic               rsp_hit;
  logic               orphan;
  logic               realloc_hit;
  logic               any_valid;
  tag_entry_t         rsp_entry;

  // A load is held back once its requester is at the in-flight limit; stores never are.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && (bus.req_we[i] || (outst_cnt[i] != CW'(MAX_OUTST)));
    end
  end

  aura_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .elig    (elig),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_oh  (gnt_oh),
    .gnt_idx (sel)
  );

  always_comb begin
    bus.proc2mem_command = MEM_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (gnt_vld) begin
      bus.proc2mem_command = bus.req_we[sel] ? MEM_STORE : MEM_LOAD;
      bus.proc2mem_addr    = bus.req_addr[sel];
      bus.proc2mem_data    = bus.req_data[sel];
    end
  end

  assign accept        = gnt_vld && (bus.mem2proc_transaction_tag != '0);
  assign alloc         = accept && !bus.req_we[sel];
  assign bus.req_ready = accept ? gnt_oh : '0;

  assign rsp_entry = tag_tbl[bus.mem2proc_data_tag];
  assign rsp_hit   = (bus.mem2proc_data_tag != '0) && rsp_entry.valid;
  assign orphan    = (bus.mem2proc_data_tag != '0) && !rsp_entry.valid;

  // Allocating onto a live entry is a memory protocol violation, unless that entry
  // is being freed by returning data in the same cycle.
  assign realloc_hit = alloc && tag_tbl[bus.mem2proc_transaction_tag].valid &&
                       !(rsp_hit && (bus.mem2proc_data_tag == bus.mem2proc_transaction_tag));

  // Free is applied before allocate so a same-cycle reuse of a tag ends valid with the new owner.
  always_comb begin
    for (int t = 0; t < NUM_TAGS; t++) begin
      tag_tbl_nxt[t] = tag_tbl[t];
      if (rsp_hit && (bus.mem2proc_data_tag == MEM_TAG'(t))) begin
        tag_tbl_nxt[t].valid = 1'b0;
      end
      if (alloc && (bus.mem2proc_transaction_tag == MEM_TAG'(t))) begin
        tag_tbl_nxt[t].valid = 1'b1;
        tag_tbl_nxt[t].owner = sel;
      end
    end
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc_v[i]         = alloc && (sel == IW'(i));
      dec_v[i]         = rsp_hit && (rsp_entry.owner == IW'(i));
      outst_cnt_nxt[i] = outst_cnt[i];
      if (inc_v[i] && !dec_v[i]) begin
        outst_cnt_nxt[i] = outst_cnt[i] + CW'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        outst_cnt_nxt[i] = outst_cnt[i] - CW'(1);
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      any_valid = any_valid | tag_tbl[t].valid;
    end
  end

  assign idle = (bus.req_valid == '0) && !any_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      quiet_cnt   <= 2'd2;
      for (int t = 0; t < NUM_TAGS; t++) begin
        tag_tbl[t] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_cnt[i] <= '0;
      end
    end else begin
      if (accept) begin
        rr_ptr <= IW'(wrap_inc(int'(sel), NUM_REQ));
      end

      rsp_valid_q <= '0;
      if (rsp_hit) begin
        rsp_valid_q[rsp_entry.owner] <= 1'b1;
        rsp_data_q                   <= bus.mem2proc_data;
      end

      if ((orphan && (quiet_cnt == 2'd0)) || realloc_hit) begin
        err_q <= 1'b1;
      end

      if (quiet_cnt != 2'd0) begin
        quiet_cnt <= quiet_cnt - 2'd1;
      end

      for (int t = 0; t < NUM_TAGS; t++) begin
        tag_tbl[t] <= tag_tbl_nxt[t];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_cnt[i] <= outst_cnt_nxt[i];
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign err_orphan_tag = err_q;

endmodule

// File: tb/tb_aura_mem_arbiter.sv
// Purpose : directed self-checking bench for aura_mem_arbiter.
// Latency : inputs driven at negedge, combinational outputs sampled #1 later,
//           registered outputs sampled at the following negedge.
// Backpr. : the bench plays both the requesters and the memory, choosing tags per cycle.
module tb_aura_mem_arbiter;
  import aura_mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic idle;
  logic err_orphan_tag;

  int n_tests = 0;
  int n_fail  = 0;

  aura_mem_arbiter_if #(.NUM_REQ(4)) bus ();

  aura_mem_arbiter #(
    .NUM_REQ   (4),
    .NUM_TAGS  (16),
    .MAX_OUTST (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .idle           (idle),
    .err_orphan_tag (err_orphan_tag)
  );

  always #5 clock = ~clock;

  task automatic clr_inputs();
    bus.req_valid                = '0;
    bus.req_we                   = '0;
    bus.req_addr                 = '0;
    bus.req_data                 = '0;
    bus.mem2proc_transaction_tag = '0;
    bus.mem2proc_data            = '0;
    bus.mem2proc_data_tag        = '0;
  endtask

  // Returns at a negedge with reset just deasserted.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clr_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_tests++; if (bus.proc2mem_command !== MEM_NONE) begin n_fail++; $display("FAIL reset_cmd: got %0d want %0d", bus.proc2mem_command, MEM_NONE); end
    n_tests++; if (bus.proc2mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.proc2mem_addr); end
    n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    n_tests++; if (err_orphan_tag !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_orphan_tag); end
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
  endtask

  task automatic test_single_load();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 32'h0000_1000;
    bus.mem2proc_transaction_tag = 4'd3;
    #1;
    n_tests++; if (bus.proc2mem_command !== MEM_LOAD) begin n_fail++; $display("FAIL single_cmd: got %0d want %0d", bus.proc2mem_command, MEM_LOAD); end
    n_tests++; if (bus.proc2mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr: got %h want 00001000", bus.proc2mem_addr); end
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", idle); end
    @(negedge clock);
    bus.req_valid = 4'b0000;
    bus.mem2proc_transaction_tag = 4'd0;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_drop: got %b want 0000", bus.req_ready); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_outst: got %b want 0", idle); end
    repeat (3) @(negedge clock);
    bus.mem2proc_data_tag = 4'd3;
    bus.mem2proc_data = 64'hDEADBEEF_00000001;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_early: got %b want 0000", bus.rsp_valid); end
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0001", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL single_rsp_data: got %h want deadbeef00000001", bus.rsp_data); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_done: got %b want 1", idle); end
    @(negedge clock);
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_pulse: got %b want 0000", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [31:0] exp_addr;
    do_reset();
    bus.req_valid = 4'b0111;
    bus.req_we    = 4'b0111;
    bus.req_addr[0] = 32'h0000_0100;
    bus.req_addr[1] = 32'h0000_0200;
    bus.req_addr[2] = 32'h0000_0300;
    bus.mem2proc_transaction_tag = 4'd1;
    for (int c = 0; c < 12; c++) begin
      exp_rdy  = 4'b0001 << (c % 3);
      exp_addr = 32'h100 * ((c % 3) + 1);
      #1;
      n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); end
      n_tests++; if (bus.proc2mem_addr !== exp_addr) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", c, bus.proc2mem_addr, exp_addr); end
      @(negedge clock);
    end
    clr_inputs();
  endtask

  task automatic test_mem_busy();
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_we    = 4'b0011;
    bus.req_addr[0] = 32'h0000_00A0;
    bus.req_addr[1] = 32'h0000_00B0;
    bus.mem2proc_transaction_tag = 4'd1;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL busy_first: got %b want 0001", bus.req_ready); end
    @(negedge clock);
    bus.mem2proc_transaction_tag = 4'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL busy_ready[%0d]: got %b want 0000", c, bus.req_ready); end
      n_tests++; if (bus.proc2mem_addr !== 32'h0000_00B0) begin n_fail++; $display("FAIL busy_hold[%0d]: got %h want 000000b0", c, bus.proc2mem_addr); end
      @(negedge clock);
    end
    bus.mem2proc_transaction_tag = 4'd2;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL busy_grant_k: got %b want 0010", bus.req_ready); end
    @(negedge clock);
    bus.mem2proc_transaction_tag = 4'd1;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL busy_next_q: got %b want 0001", bus.req_ready); end
    @(negedge clock);
    clr_inputs();
  endtask

  task automatic test_out_of_order();
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_addr[2] = 32'h0000_3000;
    bus.mem2proc_transaction_tag = 4'd5;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL ooo_v_ready: got %b want 0100", bus.req_ready); end
    @(negedge clock);
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 32'h0000_1100;
    bus.mem2proc_transaction_tag = 4'd6;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL ooo_q_ready: got %b want 0001", bus.req_ready); end
    @(negedge clock);
    bus.req_valid = 4'b0000;
    bus.mem2proc_transaction_tag = 4'd0;
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd6;
    bus.mem2proc_data = 64'hAAAA_0000_0000_0006;
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd5;
    bus.mem2proc_data = 64'hBBBB_0000_0000_0005;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL ooo_first_valid: got %b want 0001", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 64'hAAAA_0000_0000_0006) begin n_fail++; $display("FAIL ooo_first_data: got %h want aaaa000000000006", bus.rsp_data); end
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL ooo_second_valid: got %b want 0100", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 64'hBBBB_0000_0000_0005) begin n_fail++; $display("FAIL ooo_second_data: got %h want bbbb000000000005", bus.rsp_data); end
    @(negedge clock);
    #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ooo_idle: got %b want 1", idle); end
    n_tests++; if (err_orphan_tag !== 1'b0) begin n_fail++; $display("FAIL ooo_err: got %b want 0", err_orphan_tag); end
  endtask

  task automatic test_max_outst();
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_addr[1] = 32'h0000_2000;
    for (int c = 0; c < 8; c++) begin
      bus.mem2proc_transaction_tag = MEM_TAG'(c + 1);
      #1;
      n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL max_fill[%0d]: got %b want 0010", c, bus.req_ready); end
      @(negedge clock);
    end
    bus.req_valid = 4'b1010;
    bus.req_we    = 4'b1000;
    bus.req_addr[3] = 32'h0000_4000;
    bus.mem2proc_transaction_tag = 4'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL max_o_ready[%0d]: got %b want 1000", c, bus.req_ready); end
      n_tests++; if (bus.proc2mem_command !== MEM_STORE) begin n_fail++; $display("FAIL max_o_cmd[%0d]: got %0d want %0d", c, bus.proc2mem_command, MEM_STORE); end
      @(negedge clock);
    end
    bus.mem2proc_data_tag = 4'd1;
    bus.mem2proc_data = 64'hCCCC_0000_0000_0001;
    #1;
    n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL max_still_blocked: got %b want 1000", bus.req_ready); end
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL max_k_rsp: got %b want 0010", bus.rsp_valid); end
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL max_k_regrant: got %b want 0010", bus.req_ready); end
    n_tests++; if (bus.proc2mem_command !== MEM_LOAD) begin n_fail++; $display("FAIL max_k_cmd: got %0d want %0d", bus.proc2mem_command, MEM_LOAD); end
    @(negedge clock);
    clr_inputs();
    #1;
    n_tests++; if (err_orphan_tag !== 1'b0) begin n_fail++; $display("FAIL max_err: got %b want 0", err_orphan_tag); end
  endtask

  task automatic test_free_alloc();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 32'h0000_0500;
    bus.mem2proc_transaction_tag = 4'd2;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL fa_q_ready: got %b want 0001", bus.req_ready); end
    @(negedge clock);
    bus.req_valid = 4'b0010;
    bus.req_addr[1] = 32'h0000_0600;
    bus.mem2proc_transaction_tag = 4'd2;
    bus.mem2proc_data_tag = 4'd2;
    bus.mem2proc_data = 64'hDDDD_0000_0000_0002;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL fa_k_ready: got %b want 0010", bus.req_ready); end
    @(negedge clock);
    bus.req_valid = 4'b0000;
    bus.mem2proc_transaction_tag = 4'd0;
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL fa_q_rsp: got %b want 0001", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 64'hDDDD_0000_0000_0002) begin n_fail++; $display("FAIL fa_q_data: got %h want dddd000000000002", bus.rsp_data); end
    n_tests++; if (err_orphan_tag !== 1'b0) begin n_fail++; $display("FAIL fa_err: got %b want 0", err_orphan_tag); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL fa_idle_live: got %b want 0", idle); end
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd2;
    bus.mem2proc_data = 64'hEEEE_0000_0000_0002;
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL fa_k_rsp: got %b want 0010", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 64'hEEEE_0000_0000_0002) begin n_fail++; $display("FAIL fa_k_data: got %h want eeee000000000002", bus.rsp_data); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL fa_idle_done: got %b want 1", idle); end
    // Second allocate onto a live tag must be flagged.
    @(negedge clock);
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 32'h0000_0700;
    bus.mem2proc_transaction_tag = 4'd7;
    @(negedge clock);
    bus.req_valid = 4'b0100;
    bus.req_addr[2] = 32'h0000_0800;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL fa_v_ready: got %b want 0100", bus.req_ready); end
    @(negedge clock);
    clr_inputs();
    #1;
    n_tests++; if (err_orphan_tag !== 1'b1) begin n_fail++; $display("FAIL fa_realloc_err: got %b want 1", err_orphan_tag); end
  endtask

  task automatic test_orphan();
    do_reset();
    repeat (3) @(negedge clock);
    bus.mem2proc_data_tag = 4'd9;
    bus.mem2proc_data = 64'h9999_9999_9999_9999;
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL orph_rsp: got %b want 0000", bus.rsp_valid); end
    n_tests++; if (err_orphan_tag !== 1'b1) begin n_fail++; $display("FAIL orph_err: got %b want 1", err_orphan_tag); end
    repeat (3) @(negedge clock);
    #1;
    n_tests++; if (err_orphan_tag !== 1'b1) begin n_fail++; $display("FAIL orph_sticky: got %b want 1", err_orphan_tag); end
    // Reset with a load in flight.
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 32'h0000_0900;
    bus.mem2proc_transaction_tag = 4'd4;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL orph_load_ready: got %b want 0001", bus.req_ready); end
    @(negedge clock);
    clr_inputs();
    #1;
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL orph_idle_inflight: got %b want 0", idle); end
    do_reset();
    bus.mem2proc_data_tag = 4'd4;
    bus.mem2proc_data = 64'h4444_4444_4444_4444;
    #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", idle); end
    n_tests++; if (err_orphan_tag !== 1'b0) begin n_fail++; $display("FAIL rst_err_clear: got %b want 0", err_orphan_tag); end
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (err_orphan_tag !== 1'b0) begin n_fail++; $display("FAIL rst_quiet_err: got %b want 0", err_orphan_tag); end
    n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_quiet_rsp: got %b want 0000", bus.rsp_valid); end
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd4;
    @(negedge clock);
    bus.mem2proc_data_tag = 4'd0;
    #1;
    n_tests++; if (err_orphan_tag !== 1'b1) begin n_fail++; $display("FAIL rst_late_err: got %b want 1", err_orphan_tag); end
    n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_late_rsp: got %b want 0000", bus.rsp_valid); end
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_single_load();
    test_round_robin();
    test_mem_busy();
    test_out_of_order();
    test_max_outst();
    test_free_alloc();
    test_orphan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
